// File: rtl/softmax_vec_packer_if.sv
// rtl/softmax_vec_packer_if.sv - beat stream in / packed vector out bundle for softmax_vec_packer
//
// Purpose: groups the int8 beat stream (s_t*) and the packed vector output
// (input_data/in_valid/out_count/out_vec_idx) of the vector packer.
// Modports:
//    slave  - packer side: consumes the beat stream, drives the vector outputs
//    master - producer/observer side: drives the beat stream, sees the vectors
interface softmax_vec_packer_if #(
   parameter int LANES     = 8,
   parameter int VEC_ELEMS = 64,
   parameter int IDX_W     = 16
);
   logic [LANES*8-1:0]     s_tdata;
   logic [LANES-1:0]       s_tkeep;
   logic                   s_tlast;
   logic                   s_tvalid;
   logic                   s_tready;
   logic [VEC_ELEMS*8-1:0] input_data;
   logic                   in_valid;
   logic [6:0]             out_count;
   logic [IDX_W-1:0]       out_vec_idx;

   modport slave (
      input  s_tdata, s_tkeep, s_tlast, s_tvalid,
      output s_tready, input_data, in_valid, out_count, out_vec_idx
   );

   modport master (
      output s_tdata, s_tkeep, s_tlast, s_tvalid,
      input  s_tready, input_data, in_valid, out_count, out_vec_idx
   );
endinterface

// File: rtl/softmax_vec_packer.sv
// rtl/softmax_vec_packer.sv - packs an int8 beat stream into 64-element padded vectors
//
// Purpose: accumulates LANES signed int8 elements per accepted beat into a
// VEC_ELEMS-element vector. A vector closes on tlast or when the last beat
// slot is filled; it is then presented on input_data with a one-cycle in_valid,
// together with the kept-element count and a running vector index. Unused or
// masked elements are PAD_VALUE so they never win a max search downstream.
// Ports:
//    aclk  - clock, rising edge
//    rst_n - synchronous active-low reset
//    bus   - softmax_vec_packer_if.slave (s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready in,
//            input_data/in_valid/out_count/out_vec_idx out)
module softmax_vec_packer #(
   parameter int         LANES     = 8,
   parameter int         VEC_ELEMS = 64,
   parameter logic [7:0] PAD_VALUE = 8'h80,
   parameter int         IDX_W     = 16
) (
   input logic                 aclk,
   input logic                 rst_n,
   softmax_vec_packer_if.slave bus
);
   localparam int BEATS  = VEC_ELEMS / LANES;
   localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int VEC_W  = VEC_ELEMS * 8;
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
   localparam logic [VEC_W-1:0]  PAD_FILL  = {VEC_ELEMS{PAD_VALUE}};

   logic              ready_q;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [6:0]        cnt_q, cnt_d;
   logic [VEC_W-1:0]  acc_q, acc_d;
   logic [VEC_W-1:0]  data_q, data_d;
   logic [6:0]        out_cnt_q, out_cnt_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  idx_next_q, idx_next_d;

   logic              accept;
   logic              close;
   logic [6:0]        kept;
   logic [VEC_W-1:0]  merged;

   always_comb begin
      accept = bus.s_tvalid & ready_q;
      close  = accept & (bus.s_tlast | (bcnt_q == LAST_BEAT));

      // Accumulator with the current beat's lanes written into its slot.
      merged = acc_q;
      kept   = '0;
      for (int k = 0; k < LANES; k++) begin
         if (bus.s_tkeep[k]) begin
            merged[(int'(bcnt_q) * LANES + k) * 8 +: 8] = bus.s_tdata[k * 8 +: 8];
            kept = kept + 7'd1;
         end else begin
            merged[(int'(bcnt_q) * LANES + k) * 8 +: 8] = PAD_VALUE;
         end
      end

      bcnt_d     = bcnt_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      data_d     = data_q;
      out_cnt_d  = out_cnt_q;
      idx_d      = idx_q;
      idx_next_d = idx_next_q;
      valid_d    = close;

      if (close) begin
         data_d     = merged;
         out_cnt_d  = cnt_q + kept;
         idx_d      = idx_next_q;
         idx_next_d = idx_next_q + 1'b1;
         // Refill with padding so a following short vector is padded past its tlast.
         acc_d      = PAD_FILL;
         bcnt_d     = '0;
         cnt_d      = '0;
      end else if (accept) begin
         acc_d  = merged;
         bcnt_d = bcnt_q + 1'b1;
         cnt_d  = cnt_q + kept;
      end
   end

   always_ff @(posedge aclk) begin
      if (!rst_n) begin
         ready_q    <= 1'b0;
         bcnt_q     <= '0;
         cnt_q      <= '0;
         acc_q      <= PAD_FILL;
         data_q     <= '0;
         out_cnt_q  <= '0;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         idx_next_q <= '0;
      end else begin
         // Double-buffered output: the consumer never stalls, so ready stays high.
         ready_q    <= 1'b1;
         bcnt_q     <= bcnt_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         data_q     <= data_d;
         out_cnt_q  <= out_cnt_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         idx_next_q <= idx_next_d;
      end
   end

   assign bus.s_tready    = ready_q;
   assign bus.input_data  = data_q;
   assign bus.in_valid    = valid_q;
   assign bus.out_count   = out_cnt_q;
   assign bus.out_vec_idx = idx_q;
endmodule
